// File: rtl/home_inventory_sample_sequencer_pkg.sv
// Shared types and helpers for the home-inventory sample path (sequencer and event detector).
package home_inventory_sample_sequencer_pkg;

    localparam int unsigned HI_NUM_CH   = 8;
    localparam int unsigned HI_SAMPLE_W = 32;
    localparam int unsigned HI_TS_W     = 32;
    localparam int unsigned HI_CH_W     = 3;
    localparam int unsigned HI_BUS_W    = HI_NUM_CH * HI_SAMPLE_W;
    localparam int unsigned HI_FCNT_W   = 32;
    localparam int unsigned HI_DCNT_W   = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_COLLECT = 2'd1,
        SEQ_EMIT    = 2'd2
    } seq_state_t;

    // Channel n lives at bits [32n+31:32n] when flattened onto the sample bus.
    typedef logic [HI_NUM_CH-1:0][HI_SAMPLE_W-1:0] frame_t;

    // Saturating increment; counters stick at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/home_inventory_sample_sequencer_if.sv
// ADC/stub input stream and frame output bundle of the sample sequencer.
interface home_inventory_sample_sequencer_if;
    import home_inventory_sample_sequencer_pkg::*;

    logic                   enable;
    logic                   src_sel;
    logic                   adc_valid;
    logic                   adc_ready;
    logic [HI_CH_W-1:0]     adc_ch;
    logic [HI_SAMPLE_W-1:0] adc_data;
    logic                   stub_wr;
    logic [HI_CH_W-1:0]     stub_ch;
    logic [HI_SAMPLE_W-1:0] stub_data;
    logic                   stub_fire;
    logic                   sample_valid;
    logic [HI_TS_W-1:0]     ts_now;
    logic [HI_BUS_W-1:0]    sample_bus;
    logic [HI_FCNT_W-1:0]   frame_count;
    logic [HI_DCNT_W-1:0]   drop_count;
    logic                   busy;

    modport master (
        output enable, src_sel, adc_valid, adc_ch, adc_data,
               stub_wr, stub_ch, stub_data, stub_fire,
        input  adc_ready, sample_valid, ts_now, sample_bus,
               frame_count, drop_count, busy
    );

    modport slave (
        input  enable, src_sel, adc_valid, adc_ch, adc_data,
               stub_wr, stub_ch, stub_data, stub_fire,
        output adc_ready, sample_valid, ts_now, sample_bus,
               frame_count, drop_count, busy
    );

endinterface

// File: rtl/home_inventory_ts_counter.sv
// Free-running timestamp: prescaler wraps every TS_DIV clocks and bumps a 32-bit tick count.
module home_inventory_ts_counter
    import home_inventory_sample_sequencer_pkg::*;
#(
    parameter int unsigned TS_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [HI_TS_W-1:0] ts
);

    localparam int unsigned PRE_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

    logic [PRE_W-1:0] pre;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            ts  <= '0;
        end else if (pre == PRE_W'(TS_DIV - 1)) begin
            pre <= '0;
            ts  <= ts + HI_TS_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/home_inventory_sample_sequencer.sv
// Assembles ADC words or firmware stub values into 8-channel frames for the event detector,
// stamping each emitted frame with the free-running timestamp.
module home_inventory_sample_sequencer
    import home_inventory_sample_sequencer_pkg::*;
#(
    parameter int unsigned          TS_DIV  = 16,
    parameter int unsigned          TIMEOUT = 1024,
    parameter logic [HI_NUM_CH-1:0] CH_MASK = 8'hFF
) (
    input  logic                            clk,
    input  logic                            rst,
    home_inventory_sample_sequencer_if.slave seq
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    seq_state_t           state;
    logic [HI_NUM_CH-1:0] rx_mask;
    logic [TMO_W-1:0]     tmo_cnt;
    frame_t               frame;
    frame_t               shadow;
    frame_t               frame_nxt;
    frame_t               shadow_nxt;
    logic [HI_TS_W-1:0]   ts;
    logic [HI_NUM_CH-1:0] ch_bit;
    logic                 adc_fire;
    logic                 dup;
    logic                 timed_out;
    logic                 done_cur;
    logic                 done_new;
    logic                 adc_done;
    logic                 drop;
    logic                 stub_emit;

    home_inventory_ts_counter #(.TS_DIV(TS_DIV)) u_ts (
        .clk (clk),
        .rst (rst),
        .ts  (ts)
    );

    assign seq.adc_ready = !rst && seq.enable && !seq.src_sel && (state != SEQ_EMIT);
    assign seq.busy      = (state == SEQ_COLLECT);

    // done_cur: word finishes the frame in progress; done_new: word alone completes a fresh frame.
    always_comb begin
        ch_bit             = '0;
        ch_bit[seq.adc_ch] = 1'b1;
        adc_fire   = seq.adc_valid && seq.adc_ready;
        dup        = (state == SEQ_COLLECT) && |(rx_mask & ch_bit);
        timed_out  = (state == SEQ_COLLECT) && (tmo_cnt >= TMO_W'(TIMEOUT));
        done_cur   = ((rx_mask | ch_bit) & CH_MASK) == CH_MASK;
        done_new   = (ch_bit & CH_MASK) == CH_MASK;
        adc_done   = adc_fire && ((state == SEQ_IDLE) ? done_new
                                 : ((!dup && done_cur) || ((dup || timed_out) && done_new)));
        drop       = (state == SEQ_COLLECT) &&
                     (!seq.enable || seq.src_sel ||
                      (!(adc_fire && !dup && done_cur) && (dup || timed_out)));
        stub_emit  = seq.stub_fire && seq.enable && seq.src_sel;
        frame_nxt  = frame;
        if (adc_fire) frame_nxt[seq.adc_ch] = seq.adc_data;
        shadow_nxt = shadow;
        if (seq.stub_wr) shadow_nxt[seq.stub_ch] = seq.stub_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= SEQ_IDLE;
            rx_mask          <= '0;
            tmo_cnt          <= '0;
            frame            <= '0;
            shadow           <= '0;
            seq.sample_valid <= 1'b0;
            seq.ts_now       <= '0;
            seq.sample_bus   <= '0;
            seq.frame_count  <= '0;
            seq.drop_count   <= '0;
        end else begin
            seq.sample_valid <= 1'b0;
            frame            <= frame_nxt;
            shadow           <= shadow_nxt;

            unique case (state)
                SEQ_IDLE: begin
                    if (adc_fire) begin
                        rx_mask <= ch_bit;
                        tmo_cnt <= TMO_W'(1);
                        state   <= done_new ? SEQ_EMIT : SEQ_COLLECT;
                    end
                end
                SEQ_COLLECT: begin
                    if (!seq.enable || seq.src_sel) begin
                        rx_mask <= '0;
                        state   <= SEQ_IDLE;
                    end else if (adc_fire && !dup && done_cur) begin
                        rx_mask <= rx_mask | ch_bit;
                        state   <= SEQ_EMIT;
                    end else if (dup || timed_out) begin
                        // A word arriving with the drop seeds the next frame.
                        if (adc_fire) begin
                            rx_mask <= ch_bit;
                            tmo_cnt <= TMO_W'(1);
                            state   <= done_new ? SEQ_EMIT : SEQ_COLLECT;
                        end else begin
                            rx_mask <= '0;
                            state   <= SEQ_IDLE;
                        end
                    end else begin
                        if (adc_fire) rx_mask <= rx_mask | ch_bit;
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                SEQ_EMIT: begin
                    rx_mask <= '0;
                    state   <= SEQ_IDLE;
                end
                default: begin
                    rx_mask <= '0;
                    state   <= SEQ_IDLE;
                end
            endcase

            if (drop)
                seq.drop_count <= HI_DCNT_W'(sat_inc(32'(seq.drop_count), 32'h0000_FFFF));

            if (adc_done || stub_emit) begin
                seq.sample_valid <= 1'b1;
                seq.sample_bus   <= stub_emit ? shadow_nxt : frame_nxt;
                seq.ts_now       <= ts;
                seq.frame_count  <= sat_inc(seq.frame_count, 32'hFFFF_FFFF);
            end
        end
    end

endmodule

// File: tb/tb_home_inventory_sample_sequencer.sv
// Directed bench: stimulus pushes expected frames into a queue, a negedge monitor checks each strobe.
module tb_home_inventory_sample_sequencer;
    import home_inventory_sample_sequencer_pkg::*;

    localparam int unsigned TS_DIV  = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic [HI_BUS_W-1:0] bus;
        logic [31:0]         ts;
        logic [31:0]         fc;
        logic [15:0]         dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    home_inventory_sample_sequencer_if ifc();

    home_inventory_sample_sequencer #(
        .TS_DIV  (TS_DIV),
        .TIMEOUT (TIMEOUT),
        .CH_MASK (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .seq (ifc)
    );

    exp_t                              q[$];
    logic [HI_NUM_CH-1:0][31:0]        mframe;
    logic [HI_NUM_CH-1:0][31:0]        mshadow;
    logic [31:0]                       exp_fc;
    logic [15:0]                       exp_dc;
    int unsigned                       cyc;
    int                                checks   = 0;
    int                                failures = 0;

    // Bench-side clock count since reset release; the expected timestamp is cyc / TS_DIV.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [HI_BUS_W-1:0] act, input logic [HI_BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [HI_BUS_W-1:0] b, input logic [31:0] t);
        exp_t e;
        exp_fc = exp_fc + 32'd1;
        e.bus = b;
        e.ts  = t;
        e.fc  = exp_fc;
        e.dc  = exp_dc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ifc.sample_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 256'(ifc.sample_valid), 256'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sample_bus",  ifc.sample_bus, e.bus);
                chk("ts_now",      256'(ifc.ts_now), 256'(e.ts));
                chk("frame_count", 256'(ifc.frame_count), 256'(e.fc));
                chk("drop_count",  256'(ifc.drop_count), 256'(e.dc));
            end
        end
    end

    task automatic send_word(input int ch, input logic [31:0] d, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        ifc.adc_valid = 1'b1;
        ifc.adc_ch    = 3'(ch);
        ifc.adc_data  = d;
        #1;
        while (ifc.adc_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("adc_accept", 256'(ifc.adc_ready), 256'd1);
        mframe[ch] = d;
        if (last) push(mframe, 32'(cyc / TS_DIV));
        @(posedge clk);
    endtask

    task automatic adc_idle();
        @(negedge clk);
        ifc.adc_valid = 1'b0;
    endtask

    task automatic stub_cycle(input bit wr, input int ch, input logic [31:0] d, input bit fire, input bit strobe);
        @(negedge clk);
        ifc.stub_wr   = wr;
        ifc.stub_ch   = 3'(ch);
        ifc.stub_data = d;
        ifc.stub_fire = fire;
        if (wr) mshadow[ch] = d;
        if (strobe) push(mshadow, 32'(cyc / TS_DIV));
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_valid"}, 256'(ifc.sample_valid), 256'd0);
        chk({nm, "_busy"},  256'(ifc.busy), 256'd0);
        chk({nm, "_fc"},    256'(ifc.frame_count), 256'(exp_fc));
        chk({nm, "_dc"},    256'(ifc.drop_count), 256'(exp_dc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        ifc.enable    = 1'b1;
        ifc.src_sel   = 1'b0;
        ifc.adc_valid = 1'b0;
        ifc.adc_ch    = '0;
        ifc.adc_data  = '0;
        ifc.stub_wr   = 1'b0;
        ifc.stub_ch   = '0;
        ifc.stub_data = '0;
        ifc.stub_fire = 1'b0;
        mframe        = '0;
        mshadow       = '0;
        exp_fc        = '0;
        exp_dc        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("reset");
        chk("reset_ready",  256'(ifc.adc_ready), 256'd0);
        chk("reset_ts_now", 256'(ifc.ts_now), 256'd0);
        chk("reset_bus",    ifc.sample_bus, 256'd0);
        rst = 1'b0;

        // Idle 40 clocks: ts = 40/4 = 10, captured via a stub fire of the all-zero shadow
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_quiet("idle40");
        chk("idle_bus", ifc.sample_bus, 256'd0);
        ifc.src_sel   = 1'b1;
        ifc.stub_fire = 1'b1;
        push('0, 32'd10);
        @(negedge clk);
        ifc.stub_fire = 1'b0;
        ifc.src_sel   = 1'b0;

        // Full back-to-back ADC frame
        for (int c = 0; c < 8; c++) send_word(c, 32'h100 + 32'(c), c == 7);
        adc_idle();

        // Duplicate ch1 drops the frame and seeds the next one
        send_word(0, 32'h200, 1'b0);
        send_word(1, 32'h201, 1'b0);
        send_word(1, 32'h2F1, 1'b0);
        exp_dc = exp_dc + 16'd1;
        send_word(0, 32'h2A0, 1'b0);
        for (int c = 2; c < 8; c++) send_word(c, 32'h200 + 32'(c), c == 7);
        adc_idle();

        // Timeout with a partial frame
        for (int c = 0; c < 4; c++) send_word(c, 32'h300 + 32'(c), 1'b0);
        adc_idle();
        chk("t4_busy_mid", 256'(ifc.busy), 256'd1);
        repeat (20) @(negedge clk);
        exp_dc = exp_dc + 16'd1;
        check_quiet("timeout");

        // Enable fall aborts a partial frame
        send_word(0, 32'h400, 1'b0);
        send_word(1, 32'h401, 1'b0);
        @(negedge clk);
        ifc.adc_valid = 1'b0;
        ifc.enable    = 1'b0;
        repeat (2) @(negedge clk);
        exp_dc = exp_dc + 16'd1;
        check_quiet("en_abort");
        ifc.enable = 1'b1;

        // stub_fire in ADC mode is ignored
        stub_cycle(1'b0, 0, 32'h0, 1'b1, 1'b0);
        stub_cycle(1'b0, 0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_quiet("stub_adc");

        // Stub source: write ch3, then two consecutive fires (first with a same-cycle write)
        ifc.src_sel = 1'b1;
        stub_cycle(1'b1, 3, 32'hDEAD, 1'b0, 1'b0);
        stub_cycle(1'b1, 5, 32'hBEEF, 1'b1, 1'b1);
        stub_cycle(1'b0, 0, 32'h0,    1'b1, 1'b1);
        stub_cycle(1'b0, 0, 32'h0,    1'b0, 1'b0);
        ifc.src_sel = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame, then a clean frame
        for (int c = 0; c < 6; c++) send_word(c, 32'h500 + 32'(c), 1'b0);
        @(negedge clk);
        ifc.adc_valid = 1'b0;
        rst     = 1'b1;
        mframe  = '0;
        mshadow = '0;
        exp_fc  = '0;
        exp_dc  = '0;
        repeat (2) @(negedge clk);
        check_quiet("midrst");
        chk("midrst_bus", ifc.sample_bus, 256'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) send_word(c, 32'h600 + 32'(c), c == 7);
        adc_idle();

        repeat (4) @(negedge clk);
        chk("pending_frames", 256'(q.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
